// File: rtl/player_ctrl_if.sv
// player_ctrl_if: frame strobe, held buttons and committed camera outputs of player_ctrl
//   vs        frame strobe from ppl, rising edge = frame boundary
//   btn       held buttons [0]fwd [1]back [2]left [3]right [4]up [5]down [6]yaw_l [7]yaw_r [8]pitch_up [9]pitch_dn
//   p_pos_*   unsigned Q10.8 positions (y is vertical)
//   p_angle_x signed pitch in degrees, p_angle_y signed yaw in degrees
//   update    one-cycle pulse when new outputs first appear
interface player_ctrl_if;
  logic vs;
  logic [9:0] btn;
  logic [17:0] p_pos_x, p_pos_y, p_pos_z;
  logic [19:0] p_angle_x, p_angle_y;
  logic update;
  modport master(output vs, btn, input p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, update);
  modport slave(input vs, btn, output p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, update);
endinterface

// File: rtl/player_ctrl.sv
// player_ctrl: per-frame camera integrator; on each vs rise it applies held buttons to position/pitch/yaw and commits atomically
//   clk_ppl  ppl clock
//   rst      asynchronous active-high reset
//   bus      player_ctrl_if slave: vs, btn in; p_pos_x/y/z, p_angle_x/y, update out
module player_ctrl #(
  parameter int INIT_X       = 170,
  parameter int INIT_Y       = 170,
  parameter int INIT_Z       = 280,
  parameter int INIT_PITCH   = 30,
  parameter int INIT_YAW_IDX = 4,
  parameter int MOVE_STEP    = 64,
  parameter int PITCH_STEP   = 2,
  parameter int PITCH_MAX    = 89,
  parameter int POS_MIN      = 1,
  parameter int POS_MAX      = 1022
) (
  input logic clk_ppl,
  input logic rst,
  player_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SAMPLE, ANGLE, TRIG, MOVE, CLAMP, COMMIT} state_t;
  localparam logic signed [19:0] LO    = 20'(POS_MIN * 256);
  localparam logic signed [19:0] HI    = 20'(POS_MAX * 256);
  localparam logic signed [19:0] STEP  = 20'(MOVE_STEP);
  localparam logic signed [19:0] PSTEP = 20'(PITCH_STEP);
  localparam logic signed [19:0] PMAX  = 20'(PITCH_MAX);
  localparam logic signed [19:0] Z     = 20'sd0;
  state_t r_state;
  logic r_vs_d, r_update;
  logic [9:0] r_btn, w_btn;
  logic [4:0] r_idx, r_idx_n, w_idx, w_j;
  logic [1:0] w_q;
  logic [2:0] w_r;
  logic signed [9:0] r_sin, r_cos, w_a, w_b, w_sin, w_cos;
  logic signed [19:0] r_pitch, r_pitch_n, w_pitch, r_cx, r_cy, r_cz;
  logic signed [19:0] w_ts, w_tc, w_dx, w_dy, w_dz;
  logic [17:0] r_pos_x, r_pos_y, r_pos_z;
  logic w_edge;
  function automatic logic signed [9:0] tq(input logic [2:0] k);
    return k == 3'd0 ? 10'sd0 : k == 3'd1 ? 10'sd66 : k == 3'd2 ? 10'sd128 : k == 3'd3 ? 10'sd181 :
           k == 3'd4 ? 10'sd222 : k == 3'd5 ? 10'sd247 : 10'sd256;
  endfunction
  function automatic logic [17:0] clamp(input logic signed [19:0] v);
    return v < LO ? LO[17:0] : v > HI ? HI[17:0] : v[17:0];
  endfunction
  always_comb begin
    w_edge  = bus.vs & ~r_vs_d;
    // each button of an opposing pair is masked by its partner
    w_btn   = bus.btn & ~{bus.btn[8], bus.btn[9], bus.btn[6], bus.btn[7], bus.btn[4],
                          bus.btn[5], bus.btn[2], bus.btn[3], bus.btn[0], bus.btn[1]};
    w_idx   = r_btn[6] ? (r_idx == 5'd0 ? 5'd23 : r_idx - 5'd1) :
              r_btn[7] ? (r_idx == 5'd23 ? 5'd0 : r_idx + 5'd1) : r_idx;
    w_pitch = r_btn[8] ? (r_pitch + PSTEP > PMAX ? PMAX : r_pitch + PSTEP) :
              r_btn[9] ? (r_pitch - PSTEP < -PMAX ? -PMAX : r_pitch - PSTEP) : r_pitch;
    // yaw = idx*15-180 is the same angle as (idx+12 mod 24)*15 measured from 0
    w_j     = r_idx_n >= 5'd12 ? r_idx_n - 5'd12 : r_idx_n + 5'd12;
    w_q     = w_j >= 5'd18 ? 2'd3 : w_j >= 5'd12 ? 2'd2 : w_j >= 5'd6 ? 2'd1 : 2'd0;
    w_r     = 3'(w_j - 5'(w_q) * 5'd6);
    w_a     = tq(w_r);
    w_b     = tq(3'd6 - w_r);
    w_sin   = w_q[1] ? -(w_q[0] ? w_b : w_a) : (w_q[0] ? w_b : w_a);
    w_cos   = (w_q == 2'd1 || w_q == 2'd2) ? -(w_q[0] ? w_a : w_b) : (w_q[0] ? w_a : w_b);
    w_ts    = ($signed({{10{r_sin[9]}}, r_sin}) * STEP) >>> 8;
    w_tc    = ($signed({{10{r_cos[9]}}, r_cos}) * STEP) >>> 8;
    w_dx    = (r_btn[0] ? w_tc : Z) - (r_btn[1] ? w_tc : Z) - (r_btn[3] ? w_ts : Z) + (r_btn[2] ? w_ts : Z);
    w_dz    = (r_btn[0] ? w_ts : Z) - (r_btn[1] ? w_ts : Z) + (r_btn[3] ? w_tc : Z) - (r_btn[2] ? w_tc : Z);
    w_dy    = r_btn[4] ? STEP : r_btn[5] ? -STEP : Z;
  end
  always_ff @(posedge clk_ppl or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_vs_d    <= 1'b0;
      r_update  <= 1'b0;
      r_btn     <= '0;
      r_idx     <= 5'(INIT_YAW_IDX);
      r_idx_n   <= 5'(INIT_YAW_IDX);
      r_pitch   <= 20'(INIT_PITCH);
      r_pitch_n <= 20'(INIT_PITCH);
      r_sin     <= '0;
      r_cos     <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_cz      <= '0;
      r_pos_x   <= 18'(INIT_X * 256);
      r_pos_y   <= 18'(INIT_Y * 256);
      r_pos_z   <= 18'(INIT_Z * 256);
    end else begin
      r_vs_d   <= bus.vs;
      r_update <= 1'b0;
      case (r_state)
        IDLE:   r_state <= w_edge ? SAMPLE : IDLE;
        SAMPLE: begin
          r_btn   <= w_btn;
          r_state <= ANGLE;
        end
        ANGLE:  begin
          r_idx_n   <= w_idx;
          r_pitch_n <= w_pitch;
          r_state   <= TRIG;
        end
        TRIG:   begin
          r_sin   <= w_sin;
          r_cos   <= w_cos;
          r_state <= MOVE;
        end
        MOVE:   begin
          r_cx    <= $signed({2'b0, r_pos_x}) + w_dx;
          r_cy    <= $signed({2'b0, r_pos_y}) + w_dy;
          r_cz    <= $signed({2'b0, r_pos_z}) + w_dz;
          r_state <= CLAMP;
        end
        // registers written here are visible throughout the COMMIT cycle
        CLAMP:  begin
          r_pos_x  <= clamp(r_cx);
          r_pos_y  <= clamp(r_cy);
          r_pos_z  <= clamp(r_cz);
          r_pitch  <= r_pitch_n;
          r_idx    <= r_idx_n;
          r_update <= 1'b1;
          r_state  <= COMMIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.p_pos_x   = r_pos_x;
  assign bus.p_pos_y   = r_pos_y;
  assign bus.p_pos_z   = r_pos_z;
  assign bus.p_angle_x = r_pitch;
  assign bus.p_angle_y = $signed({15'd0, r_idx}) * 20'sd15 - 20'sd180;
  assign bus.update    = r_update;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: randomized and directed frame stimulus checked against a degree-based camera model
module tb_player_ctrl;
  logic clk_ppl = 1'b0;
  logic rst;
  int errors = 0, checks = 0;
  int mx, my, mz, mp, myaw;
  always #5 clk_ppl = ~clk_ppl;
  player_ctrl_if bus();
  player_ctrl dut (.clk_ppl(clk_ppl), .rst(rst), .bus(bus));
  function automatic int tq(int k);
    case (k)
      0: return 0;
      1: return 66;
      2: return 128;
      3: return 181;
      4: return 222;
      5: return 247;
      default: return 256;
    endcase
  endfunction
  function automatic int sinq(int d);
    int a = ((d % 360) + 360) % 360;
    if (a <= 90) return tq(a / 15);
    if (a <= 180) return tq((180 - a) / 15);
    if (a <= 270) return -tq((a - 180) / 15);
    return -tq((360 - a) / 15);
  endfunction
  function automatic int clampi(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  task automatic model_reset;
    mx = 170 * 256; my = 170 * 256; mz = 280 * 256; mp = 30; myaw = -120;
  endtask
  task automatic model_frame(input logic [9:0] b);
    bit f  = b[0] && !b[1], bk = b[1] && !b[0], lf = b[2] && !b[3], rt = b[3] && !b[2];
    bit up = b[4] && !b[5], dn = b[5] && !b[4], yl = b[6] && !b[7], yr = b[7] && !b[6];
    bit pu = b[8] && !b[9], pd = b[9] && !b[8];
    int s, c, ts, tc;
    myaw += yr ? 15 : yl ? -15 : 0;
    if (myaw < -180) myaw += 360;
    if (myaw > 165) myaw -= 360;
    mp = pu ? clampi(mp + 2, -89, 89) : pd ? clampi(mp - 2, -89, 89) : mp;
    s  = sinq(myaw);
    c  = sinq(myaw + 90);
    ts = (s * 64) >>> 8;
    tc = (c * 64) >>> 8;
    mx = clampi(mx + (f ? tc : 0) - (bk ? tc : 0) - (rt ? ts : 0) + (lf ? ts : 0), 256, 261632);
    mz = clampi(mz + (f ? ts : 0) - (bk ? ts : 0) + (rt ? tc : 0) - (lf ? tc : 0), 256, 261632);
    my = clampi(my + (up ? 64 : 0) - (dn ? 64 : 0), 256, 261632);
  endtask
  task automatic run_frame(input logic [9:0] b);
    int lat = 0;
    @(negedge clk_ppl); bus.vs = 1'b0;
    @(negedge clk_ppl); bus.btn = b; bus.vs = 1'b1;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk_ppl); #1;
      if (bus.update) lat = i;
    end
    model_frame(b);
    checks++; if (lat != 6) begin errors++; $display("FAIL latency btn=%h: got %0d expected 6", b, lat); end
    checks++; if (int'(bus.p_pos_x) != mx) begin errors++; $display("FAIL pos_x btn=%h: got %0d expected %0d", b, bus.p_pos_x, mx); end
    checks++; if (int'(bus.p_pos_y) != my) begin errors++; $display("FAIL pos_y btn=%h: got %0d expected %0d", b, bus.p_pos_y, my); end
    checks++; if (int'(bus.p_pos_z) != mz) begin errors++; $display("FAIL pos_z btn=%h: got %0d expected %0d", b, bus.p_pos_z, mz); end
    checks++; if (int'($signed(bus.p_angle_x)) != mp) begin errors++; $display("FAIL pitch btn=%h: got %0d expected %0d", b, $signed(bus.p_angle_x), mp); end
    checks++; if (int'($signed(bus.p_angle_y)) != myaw) begin errors++; $display("FAIL yaw btn=%h: got %0d expected %0d", b, $signed(bus.p_angle_y), myaw); end
    @(posedge clk_ppl); #1;
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL update_width: got %b expected 0", bus.update); end
  endtask
  task automatic test_reset;
    rst = 1'b1; bus.vs = 1'b0; bus.btn = '0;
    #3;
    checks++; if (bus.p_pos_x !== 18'd43520) begin errors++; $display("FAIL reset_x: got %0d expected 43520", bus.p_pos_x); end
    checks++; if (bus.p_pos_y !== 18'd43520) begin errors++; $display("FAIL reset_y: got %0d expected 43520", bus.p_pos_y); end
    checks++; if (bus.p_pos_z !== 18'd71680) begin errors++; $display("FAIL reset_z: got %0d expected 71680", bus.p_pos_z); end
    checks++; if (bus.p_angle_x !== 20'sd30) begin errors++; $display("FAIL reset_pitch: got %0d expected 30", $signed(bus.p_angle_x)); end
    checks++; if (bus.p_angle_y !== -20'sd120) begin errors++; $display("FAIL reset_yaw: got %0d expected -120", $signed(bus.p_angle_y)); end
    checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected 0", bus.update); end
    repeat (2) @(posedge clk_ppl);
    @(negedge clk_ppl); rst = 1'b0;
    model_reset();
  endtask
  task automatic test_fwd;
    run_frame(10'b1);
    checks++; if (bus.p_pos_x !== 18'd43488) begin errors++; $display("FAIL fwd_x: got %0d expected 43488", bus.p_pos_x); end
    checks++; if (bus.p_pos_z !== 18'd71624) begin errors++; $display("FAIL fwd_z: got %0d expected 71624", bus.p_pos_z); end
    checks++; if (bus.p_pos_y !== 18'd43520) begin errors++; $display("FAIL fwd_y: got %0d expected 43520", bus.p_pos_y); end
  endtask
  task automatic test_yaw_wrap;
    repeat (5) run_frame(10'h040);
    checks++; if (bus.p_angle_y !== 20'sd165) begin errors++; $display("FAIL yaw_wrap_l: got %0d expected 165", $signed(bus.p_angle_y)); end
    run_frame(10'h080);
    checks++; if (bus.p_angle_y !== -20'sd180) begin errors++; $display("FAIL yaw_wrap_r: got %0d expected -180", $signed(bus.p_angle_y)); end
  endtask
  task automatic test_pitch;
    repeat (40) run_frame(10'h100);
    checks++; if (bus.p_angle_x !== 20'sd89) begin errors++; $display("FAIL pitch_max: got %0d expected 89", $signed(bus.p_angle_x)); end
    repeat (95) run_frame(10'h200);
    checks++; if (bus.p_angle_x !== -20'sd89) begin errors++; $display("FAIL pitch_min: got %0d expected -89", $signed(bus.p_angle_x)); end
  endtask
  task automatic test_clamp;
    repeat (3420) run_frame(10'h010);
    checks++; if (bus.p_pos_y !== 18'd261632) begin errors++; $display("FAIL clamp_max_y: got %0d expected 261632", bus.p_pos_y); end
    repeat (690) run_frame(10'h001);
    checks++; if (bus.p_pos_x !== 18'd256) begin errors++; $display("FAIL clamp_min_x: got %0d expected 256", bus.p_pos_x); end
  endtask
  task automatic test_fwd_back;
    int ex = mx, ey = my, ez = mz;
    run_frame(10'h3ff);
    checks++; if (int'(bus.p_pos_x) != ex || int'(bus.p_pos_y) != ey || int'(bus.p_pos_z) != ez) begin
      errors++; $display("FAIL cancel_pos: got %0d/%0d/%0d expected %0d/%0d/%0d", bus.p_pos_x, bus.p_pos_y, bus.p_pos_z, ex, ey, ez);
    end
  endtask
  task automatic test_back_to_back;
    int n = 0;
    @(negedge clk_ppl); bus.vs = 1'b0;
    @(negedge clk_ppl); bus.btn = 10'h008; bus.vs = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk_ppl); #1;
      if (bus.update) n++;
      if (i == 2) bus.vs = 1'b0;
      if (i == 3) bus.vs = 1'b1;
    end
    model_frame(10'h008);
    checks++; if (n != 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", n); end
    checks++; if (int'(bus.p_pos_x) != mx) begin errors++; $display("FAIL b2b_x: got %0d expected %0d", bus.p_pos_x, mx); end
    checks++; if (int'(bus.p_pos_z) != mz) begin errors++; $display("FAIL b2b_z: got %0d expected %0d", bus.p_pos_z, mz); end
  endtask
  task automatic test_mid_reset;
    int n = 0;
    @(negedge clk_ppl); bus.vs = 1'b0;
    @(negedge clk_ppl); bus.btn = 10'h001; bus.vs = 1'b1;
    repeat (4) @(posedge clk_ppl);
    #1; rst = 1'b1; #1;
    checks++; if (bus.p_pos_x !== 18'd43520) begin errors++; $display("FAIL midrst_x: got %0d expected 43520", bus.p_pos_x); end
    checks++; if (bus.p_angle_y !== -20'sd120) begin errors++; $display("FAIL midrst_yaw: got %0d expected -120", $signed(bus.p_angle_y)); end
    checks++; if (bus.p_angle_x !== 20'sd30) begin errors++; $display("FAIL midrst_pitch: got %0d expected 30", $signed(bus.p_angle_x)); end
    bus.vs = 1'b0;
    repeat (2) @(posedge clk_ppl);
    @(negedge clk_ppl); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_ppl); #1;
      if (bus.update) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL midrst_update: got %0d pulses expected 0", n); end
    model_reset();
  endtask
  task automatic test_random;
    for (int i = 0; i < 80; i++) run_frame(10'($urandom));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_fwd();
    test_yaw_wrap();
    test_pitch();
    test_clamp();
    test_fwd_back();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
